morse_symbol_serializer: RTL and testbench

- Parametrised successor to the fixed 11-bit Morse shift register.
- Accepts one Morse symbol pattern and its bit length over a valid/ready handshake.
- Shifts the pattern out LSB-first, each bit held for a programmable number of clock cycles (one Morse time unit), then appends a fixed inter-symbol gap of zeros.
- Sits between the character-to-pattern lookup and the LED/buzzer driver; reports busy and a done pulse per symbol.

---
 rtl/morse_symbol_serializer.sv | 120 ++++++++++++
 tb/tb_morse_symbol_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_symbol_serializer.sv
// Morse symbol serializer: accepts a pattern/length pair over valid/ready and shifts it
// out LSB-first, DIV cycles per bit, followed by GAP_UNITS units of silence.
module morse_symbol_serializer #(
  parameter int WIDTH     = 11,
  parameter int LEN_W     = 4,
  parameter int DIV       = 4,
  parameter int GAP_UNITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             clear,
  output logic             bit_out,
  output logic             busy,
  output logic             done
);

  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W  = (GAP_UNITS > 0) ? $clog2(GAP_UNITS + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DIV - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(WIDTH);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_UNITS);
  localparam bit                HAS_GAP  = (GAP_UNITS > 0);

  logic [1:0]        state;
  logic [WIDTH-1:0]  shreg;
  logic [TICK_W-1:0] tick_cnt;
  logic [LEN_W-1:0]  bits_left;
  logic [GAP_W-1:0]  gap_left;
  logic              done_q;

  logic              tick;
  logic [LEN_W-1:0]  len_clamped;

  assign tick        = (tick_cnt == TICK_MAX);
  assign len_clamped = (in_len > LEN_MAX) ? LEN_MAX : in_len;

  assign in_ready = (state == IDLE) && !clear;
  assign busy     = (state != IDLE);
  assign bit_out  = (state == SHIFT) && shreg[0];
  assign done     = done_q;

  // clear wins over everything but reset; done is a one-cycle pulse by default-low assignment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      tick_cnt  <= '0;
      bits_left <= '0;
      gap_left  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        shreg     <= '0;
        tick_cnt  <= '0;
        bits_left <= '0;
        gap_left  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              shreg     <= in_data;
              bits_left <= len_clamped;
              tick_cnt  <= '0;
              if (len_clamped != '0) begin
                state <= SHIFT;
              end else if (HAS_GAP) begin
                state    <= GAP;
                gap_left <= GAP_LOAD;
              end else begin
                done_q <= 1'b1;
              end
            end
          end

          SHIFT: begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
              shreg     <= shreg >> 1;
              bits_left <= bits_left - 1'b1;
              if (bits_left == LEN_W'(1)) begin
                if (HAS_GAP) begin
                  state    <= GAP;
                  gap_left <= GAP_LOAD;
                end else begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                end
              end
            end
          end

          GAP: begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
              gap_left <= gap_left - 1'b1;
              if (gap_left == GAP_W'(1)) begin
                state  <= IDLE;
                done_q <= 1'b1;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_symbol_serializer.sv
// Bench for morse_symbol_serializer: vector table, random symbols against a waveform
// model, and hand-written reset/clear/back-to-back/DIV=1 sequences.
`timescale 1ns/1ps
module tb_morse_symbol_serializer;

  localparam int W   = 11;
  localparam int DIV = 4;
  localparam int G   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, clear, bit_out, busy, done;
  logic [W-1:0]  in_data;
  logic [3:0]    in_len;

  logic          in_valid2, in_ready2, clear2, bit_out2, busy2, done2;
  logic [W-1:0]  in_data2;
  logic [3:0]    in_len2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   len;
    int           expBusy;
    int           expHigh;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  morse_symbol_serializer #(.WIDTH(W), .LEN_W(4), .DIV(DIV), .GAP_UNITS(G)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .clear(clear),
    .bit_out(bit_out), .busy(busy), .done(done)
  );

  morse_symbol_serializer #(.WIDTH(W), .LEN_W(4), .DIV(1), .GAP_UNITS(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_len(in_len2), .clear(clear2),
    .bit_out(bit_out2), .busy(busy2), .done(done2)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Expected waveform is built as a list of per-cycle bit values from the pattern rules.
  task automatic applyStimulus(input logic [W-1:0] d, input logic [3:0] l, input bit keepValid,
                               output int highCnt, output int busyCnt);
    bit q[$];
    int len;
    len = (int'(l) > W) ? W : int'(l);
    for (int u = 0; u < len; u++)
      for (int r = 0; r < DIV; r++) q.push_back(d[u]);
    for (int r = 0; r < G * DIV; r++) q.push_back(1'b0);
    highCnt = 0;
    busyCnt = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    checkOutput("in_ready_at_accept", int'(in_ready), 1);
    stepCycle();
    for (int k = 0; k < q.size(); k++) begin
      if (keepValid) begin
        in_data = W'($urandom);
        in_len  = 4'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (bit_out) highCnt++;
      if (busy) busyCnt++;
      checkOutput("bit_out", int'(bit_out), int'(q[k]));
      checkOutput("busy", int'(busy), 1);
      checkOutput("done_early", int'(done), 0);
      stepCycle();
    end
    in_valid = keepValid;
    checkOutput("done", int'(done), 1);
    checkOutput("busy_in_done", int'(busy), 0);
    checkOutput("in_ready_in_done", int'(in_ready), 1);
    checkOutput("bit_out_in_done", int'(bit_out), 0);
    if (!keepValid) begin
      stepCycle();
      checkOutput("done_cleared", int'(done), 0);
    end
  endtask

  task automatic watchIdle(input int cycles, input string name);
    int sawDone;
    int sawBusy;
    sawDone = 0;
    sawBusy = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) sawDone++;
      if (busy) sawBusy++;
      stepCycle();
    end
    checkOutput({name, "_spurious_done"}, sawDone, 0);
    checkOutput({name, "_spurious_busy"}, sawBusy, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int h, b;
    logic [W-1:0] rd;
    logic [3:0]   rl;
    bit           keep;

    vecs[0] = '{11'b000_0001_0111, 4'd5,  32, 16};
    vecs[1] = '{11'h155,           4'd0,  12,  0};
    vecs[2] = '{11'h7FF,           4'd15, 56, 44};
    vecs[3] = '{11'h7FF,           4'd3,  24, 12};
    vecs[4] = '{11'h2AA,           4'd10, 52, 20};
    vecs[5] = '{11'h7F0,           4'd4,  28,  0};
    vecs[6] = '{11'h400,           4'd11, 56,  4};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_len = '0; clear = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; in_len2 = '0; clear2 = 1'b0;
    #1;
    checkOutput("reset_bit_out", int'(bit_out), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].data, vecs[i].len, 1'b0, h, b);
      checkOutput($sformatf("vec%0d_busy_cycles", i), b, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d_high_cycles", i), h, vecs[i].expHigh);
    end

    // Back-to-back: in_valid held high, noise on in_data while busy, second accept in done cycle
    applyStimulus(11'b000_0001_0111, 4'd5, 1'b1, h, b);
    applyStimulus(11'b000_0000_0101, 4'd3, 1'b0, h, b);
    checkOutput("b2b_second_high_cycles", h, 8);

    // Async reset mid-SHIFT, between edges
    in_valid = 1'b1; in_data = 11'b000_0001_0111; in_len = 4'd5;
    stepCycle();
    in_valid = 1'b0;
    stepCycle();
    checkOutput("pre_reset_bit_out", int'(bit_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_bit_out", int'(bit_out), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    checkOutput("async_reset_done", int'(done), 0);
    checkOutput("async_reset_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    watchIdle(40, "after_reset");

    // clear during bit 2 of the nominal symbol
    in_valid = 1'b1; in_data = 11'b000_0001_0111; in_len = 4'd5;
    stepCycle();
    in_valid = 1'b0;
    repeat (8) stepCycle();
    checkOutput("bit2_before_clear", int'(bit_out), 1);
    clear = 1'b1;
    #1;
    checkOutput("in_ready_during_clear", int'(in_ready), 0);
    stepCycle();
    clear = 1'b0;
    #1;
    checkOutput("clear_busy", int'(busy), 0);
    checkOutput("clear_bit_out", int'(bit_out), 0);
    checkOutput("clear_done", int'(done), 0);
    checkOutput("clear_in_ready_after", int'(in_ready), 1);
    watchIdle(40, "after_clear");

    // clear in IDLE blocks a concurrent accept
    clear = 1'b1; in_valid = 1'b1; in_data = 11'h7FF; in_len = 4'd5;
    #1;
    checkOutput("idle_clear_in_ready", int'(in_ready), 0);
    stepCycle();
    clear = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("idle_clear_no_accept", int'(busy), 0);
    watchIdle(5, "idle_clear");

    for (int i = 0; i < 25; i++) begin
      rd   = W'($urandom);
      rl   = 4'($urandom_range(0, 15));
      keep = (i != 24) && ($urandom_range(0, 3) == 0);
      applyStimulus(rd, rl, keep, h, b);
      checkOutput("rand_busy_cycles", b, (((int'(rl) > W) ? W : int'(rl)) + G) * DIV);
    end

    // DIV=1, no gap: zero length completes immediately; a 3-bit pattern takes 3 cycles
    in_valid2 = 1'b1; in_data2 = 11'h7FF; in_len2 = 4'd0;
    checkOutput("dut2_in_ready", int'(in_ready2), 1);
    stepCycle();
    in_valid2 = 1'b0;
    checkOutput("dut2_zero_done", int'(done2), 1);
    checkOutput("dut2_zero_busy", int'(busy2), 0);
    checkOutput("dut2_zero_bit_out", int'(bit_out2), 0);
    checkOutput("dut2_zero_in_ready", int'(in_ready2), 1);
    stepCycle();
    checkOutput("dut2_zero_done_cleared", int'(done2), 0);
    in_valid2 = 1'b1; in_data2 = 11'b000_0000_0101; in_len2 = 4'd3;
    stepCycle();
    in_valid2 = 1'b0;
    checkOutput("dut2_bit0", int'(bit_out2), 1);
    checkOutput("dut2_busy0", int'(busy2), 1);
    stepCycle();
    checkOutput("dut2_bit1", int'(bit_out2), 0);
    stepCycle();
    checkOutput("dut2_bit2", int'(bit_out2), 1);
    checkOutput("dut2_no_early_done", int'(done2), 0);
    stepCycle();
    checkOutput("dut2_done", int'(done2), 1);
    checkOutput("dut2_done_busy", int'(busy2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
